// File: rtl/sdm_nc_pkg.sv
// Shared types and defaults for the SDM noise-cancellation sequencer.
// State encoding, default parameters and window-sum sizing.
package sdm_nc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SETTLE = 3'd2,
    TRACK  = 3'd3,
    HOLD   = 3'd4
  } state_e;

  localparam int          W_DEF          = 15;
  localparam logic [14:0] GAIN_INIT_DEF  = 15'h4000;
  localparam int          STEP_LOG2_DEF  = 4;
  localparam int          WIN_LOG2_DEF   = 6;
  localparam int          THRESH_DEF     = 8;
  localparam int          CLR_CYC_DEF    = 4;
  localparam int          SETTLE_CYC_DEF = 64;
  localparam int          LOCK_WIN_DEF   = 4;

  // Signed window sum must hold +/-2^win_log2.
  function automatic int sum_w(input int win_log2);
    return win_log2 + 2;
  endfunction

endpackage

// File: rtl/sdm_nc_gain_step.sv
// Gain word register with saturating step up/down.
// Resets to its initial gain independently of the sequencer.
module sdm_nc_gain_step
  import sdm_nc_pkg::*;
#(
  parameter int           W         = W_DEF,
  parameter logic [W-1:0] GAIN_INIT = W'(GAIN_INIT_DEF),
  parameter int           STEP_LOG2 = STEP_LOG2_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         up_i,
  input  logic         dn_i,
  output logic [W-1:0] gain_o
);

  localparam logic [W:0] ONE  = {{W{1'b0}}, 1'b1};
  localparam logic [W:0] STEP = ONE << STEP_LOG2;

  logic [W-1:0] gain_q, gain_d;
  logic [W:0]   inc, dec;

  // Carry/borrow out of the extended sum selects the clamp value.
  always_comb begin
    inc    = {1'b0, gain_q} + STEP;
    dec    = {1'b0, gain_q} - STEP;
    gain_d = gain_q;
    if (up_i) begin
      gain_d = inc[W] ? '1 : inc[W-1:0];
    end else if (dn_i) begin
      gain_d = dec[W] ? '0 : dec[W-1:0];
    end
  end

  // Gain register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gain_q <= GAIN_INIT;
    end else begin
      gain_q <= gain_d;
    end
  end

  assign gain_o = gain_q;

endmodule

// File: rtl/sdm_nc_seq.sv
// Bring-up sequencer and sign-sign gain tracker for the SDM
// noise-cancellation datapath: clear, settle, then track the gain.
module sdm_nc_seq
  import sdm_nc_pkg::*;
#(
  parameter int           W          = W_DEF,
  parameter logic [W-1:0] GAIN_INIT  = W'(GAIN_INIT_DEF),
  parameter int           STEP_LOG2  = STEP_LOG2_DEF,
  parameter int           WIN_LOG2   = WIN_LOG2_DEF,
  parameter int           THRESH     = THRESH_DEF,
  parameter int           CLR_CYC    = CLR_CYC_DEF,
  parameter int           SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int           LOCK_WIN   = LOCK_WIN_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         enable,
  input  logic         freeze,
  input  logic         err_valid,
  input  logic         err_sign,
  output logic         acc_clr,
  output logic         nc_en,
  output logic [W-1:0] gain,
  output logic         locked,
  output logic         busy
);

  localparam int SW     = sum_w(WIN_LOG2);
  localparam int PH_MAX = (CLR_CYC > SETTLE_CYC) ? CLR_CYC : SETTLE_CYC;
  localparam int PW     = $clog2(PH_MAX + 1);
  localparam int LW     = $clog2(LOCK_WIN + 1);

  localparam logic signed [SW-1:0] TH_P  = SW'(THRESH);
  localparam logic signed [SW-1:0] TH_N  = -TH_P;
  localparam logic signed [SW-1:0] ONE_P = SW'(1);
  localparam logic signed [SW-1:0] ONE_N = -ONE_P;

  state_e               state_q, state_d;
  logic [PW-1:0]        ph_q, ph_d;
  logic [WIN_LOG2-1:0]  wcnt_q, wcnt_d;
  logic signed [SW-1:0] sum_q, sum_d, sum_nx;
  logic [LW-1:0]        lk_q, lk_d;
  logic                 acc_clr_q, nc_en_q, busy_q, locked_q;
  logic                 take, close, up, dn;

  // Next state and phase counter; enable low overrides everything.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = CLEAR;
          ph_d    = '0;
        end
      end
      CLEAR: begin
        if (ph_q == PW'(CLR_CYC - 1)) begin
          state_d = SETTLE;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      SETTLE: begin
        if (ph_q == PW'(SETTLE_CYC - 1)) begin
          state_d = freeze ? HOLD : TRACK;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      TRACK: begin
        if (freeze) state_d = HOLD;
      end
      HOLD: begin
        if (!freeze) state_d = TRACK;
      end
      default: begin
        state_d = IDLE;
        ph_d    = '0;
      end
    endcase
    if (!enable) begin
      state_d = IDLE;
      ph_d    = '0;
    end
  end

  // Window sum, decision on the closing sample, and lock counter.
  always_comb begin
    take   = (state_q == TRACK) && (state_d == TRACK) && err_valid;
    sum_nx = sum_q + (err_sign ? ONE_P : ONE_N);
    close  = take && (wcnt_q == '1);
    up     = close && (sum_nx >= TH_P);
    dn     = close && (sum_nx <= TH_N);
    wcnt_d = wcnt_q;
    sum_d  = sum_q;
    lk_d   = lk_q;
    if (state_d != TRACK) begin
      wcnt_d = '0;
      sum_d  = '0;
    end else if (take) begin
      wcnt_d = close ? '0 : wcnt_q + WIN_LOG2'(1);
      sum_d  = close ? '0 : sum_nx;
    end
    if (state_d == IDLE) begin
      lk_d = '0;
    end else if (up || dn) begin
      lk_d = '0;
    end else if (close && (lk_q != LW'(LOCK_WIN))) begin
      lk_d = lk_q + LW'(1);
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      ph_q      <= '0;
      wcnt_q    <= '0;
      sum_q     <= '0;
      lk_q      <= '0;
      acc_clr_q <= 1'b0;
      nc_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      wcnt_q    <= wcnt_d;
      sum_q     <= sum_d;
      lk_q      <= lk_d;
      acc_clr_q <= (state_d == CLEAR);
      nc_en_q   <= (state_d inside {TRACK, HOLD});
      busy_q    <= (state_d inside {CLEAR, SETTLE});
      locked_q  <= (lk_d == LW'(LOCK_WIN));
    end
  end

  sdm_nc_gain_step #(
    .W         (W),
    .GAIN_INIT (GAIN_INIT),
    .STEP_LOG2 (STEP_LOG2)
  ) u_gain (
    .clk    (clk),
    .rstn   (rstn),
    .up_i   (up),
    .dn_i   (dn),
    .gain_o (gain)
  );

  assign acc_clr = acc_clr_q;
  assign nc_en   = nc_en_q;
  assign busy    = busy_q;
  assign locked  = locked_q;

endmodule

// File: tb/tb_sdm_nc_seq.sv
// Scoreboard bench for sdm_nc_seq: three instances differing only
// in initial gain, checked every cycle against a cycle-count model.
module tb_sdm_nc_seq;

  localparam int C    = 4;
  localparam int S    = 64;
  localparam int WN   = 64;
  localparam int TH   = 8;
  localparam int LK   = 4;
  localparam int ST   = 16;
  localparam int GMAX = 32767;

  typedef logic [18:0]       obs_t;
  typedef logic [2:0][18:0]  exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic enable = 1'b0;
  logic freeze = 1'b0;
  logic err_valid = 1'b0;
  logic err_sign = 1'b0;
  logic [2:0] acc_clr, nc_en, locked, busy;
  logic [14:0] gain0, gain1, gain2;

  int errs = 0;
  int checks = 0;
  exp_t q[$];

  int m_cyc, m_n, m_sum, m_lk;
  bit m_hold;
  int m_g[3];

  always #5 clk = ~clk;

  sdm_nc_seq #(.GAIN_INIT(15'h4000)) u0 (
    .clk(clk), .rstn(rstn), .enable(enable), .freeze(freeze),
    .err_valid(err_valid), .err_sign(err_sign), .acc_clr(acc_clr[0]),
    .nc_en(nc_en[0]), .gain(gain0), .locked(locked[0]), .busy(busy[0])
  );
  sdm_nc_seq #(.GAIN_INIT(15'h7FF8)) u1 (
    .clk(clk), .rstn(rstn), .enable(enable), .freeze(freeze),
    .err_valid(err_valid), .err_sign(err_sign), .acc_clr(acc_clr[1]),
    .nc_en(nc_en[1]), .gain(gain1), .locked(locked[1]), .busy(busy[1])
  );
  sdm_nc_seq #(.GAIN_INIT(15'd8)) u2 (
    .clk(clk), .rstn(rstn), .enable(enable), .freeze(freeze),
    .err_valid(err_valid), .err_sign(err_sign), .acc_clr(acc_clr[2]),
    .nc_en(nc_en[2]), .gain(gain2), .locked(locked[2]), .busy(busy[2])
  );

  function automatic int gi(int i);
    case (i)
      0:       return 16384;
      1:       return 32760;
      default: return 8;
    endcase
  endfunction

  function automatic obs_t act(int i);
    case (i)
      0:       return {acc_clr[0], nc_en[0], busy[0], locked[0], gain0};
      1:       return {acc_clr[1], nc_en[1], busy[1], locked[1], gain1};
      default: return {acc_clr[2], nc_en[2], busy[2], locked[2], gain2};
    endcase
  endfunction

  task automatic chk(string nm, obs_t a, obs_t e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s t=%0t: got clr/en/busy/lock=%b gain=%0d, expected clr/en/busy/lock=%b gain=%0d",
               nm, $time, a[18:15], a[14:0], e[18:15], e[14:0]);
    end
  endtask

  // Expected outputs follow from cycles elapsed since enable.
  function automatic exp_t expect_now();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      e[i] = {(m_cyc >= 1 && m_cyc <= C), (m_cyc > C + S),
              (m_cyc >= 1 && m_cyc <= C + S), (m_lk == LK),
              15'(m_g[i])};
    end
    return e;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_n = 0; m_sum = 0; m_lk = 0; m_hold = 0;
    for (int i = 0; i < 3; i++) m_g[i] = gi(i);
  endtask

  task automatic model_edge(bit en, bit frz, bit ev, bit es);
    bit running, accept, up, dn;
    if (!en) begin
      m_cyc = 0; m_n = 0; m_sum = 0; m_lk = 0; m_hold = 0;
      return;
    end
    running = (m_cyc > C + S);
    accept  = running && !m_hold && !frz && ev;
    if (accept) begin
      m_n++;
      m_sum += es ? 1 : -1;
      if (m_n == WN) begin
        up = (m_sum >= TH);
        dn = (m_sum <= -TH);
        for (int i = 0; i < 3; i++) begin
          if (up) m_g[i] = (m_g[i] + ST > GMAX) ? GMAX : m_g[i] + ST;
          else if (dn) m_g[i] = (m_g[i] - ST < 0) ? 0 : m_g[i] - ST;
        end
        if (up || dn) m_lk = 0;
        else if (m_lk < LK) m_lk++;
        m_n = 0;
        m_sum = 0;
      end
    end else if (frz || m_cyc < C + S) begin
      m_n = 0;
      m_sum = 0;
    end
    if (m_cyc <= C + S) m_cyc++;
    m_hold = frz;
  endtask

  task automatic step(bit rn, bit en, bit frz, bit ev, bit es);
    @(negedge clk);
    #1;
    rstn = rn; enable = en; freeze = frz;
    err_valid = ev; err_sign = es;
    if (!rn) model_reset();
    else model_edge(en, frz, ev, es);
    q.push_back(expect_now());
  endtask

  task automatic run(bit en, bit frz, bit ev, bit es);
    step(1'b1, en, frz, ev, es);
  endtask

  // kind: 0 all negative, 1 all positive, 2 alternating, 3 random
  task automatic samples(int n, int kind);
    bit s;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(3) == 0) run(1, 0, 0, 1'($urandom_range(1)));
      case (kind)
        0:       s = 1'b0;
        1:       s = 1'b1;
        2:       s = k[0];
        default: s = 1'($urandom_range(1));
      endcase
      run(1, 0, 1, s);
    end
  endtask

  task automatic async_rst();
    exp_t e;
    @(negedge clk);
    #1;
    rstn = 0; enable = 0; freeze = 0; err_valid = 0;
    #2;
    model_reset();
    e = expect_now();
    for (int i = 0; i < 3; i++) chk($sformatf("async_rst%0d", i), act(i), e[i]);
    q.push_back(e);
  endtask

  // Monitor: compare each posedge's result at the following negedge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int i = 0; i < 3; i++) chk($sformatf("inst%0d", i), act(i), e[i]);
    end
  end

  initial begin
    exp_t e0;
    bit en_v, fz_v, pfz, ev, es;
    int bias;

    #1 rstn = 0;
    #2;
    model_reset();
    e0 = expect_now();
    for (int i = 0; i < 3; i++) chk($sformatf("reset%0d", i), act(i), e0[i]);
    repeat (3) step(0, 0, 0, 0, 0);
    repeat (2) run(0, 0, 1, 1);

    for (int k = 0; k < C + S + 2; k++)
      run(1, 0, 1'($urandom_range(1)), 1'($urandom_range(1)));
    samples(64, 0);
    samples(64, 1);
    samples(64, 1);
    repeat (4) samples(64, 2);
    samples(64, 0);

    samples(30, 1);
    run(1, 1, 0, 0);
    repeat (100) run(1, 1, 1, 1'($urandom_range(1)));
    run(1, 0, 1, 1);
    samples(63, 1);
    repeat (5) run(1, 0, 0, 0);
    samples(1, 1);
    repeat (3) run(1, 0, 0, 0);

    run(0, 0, 0, 0);
    repeat (20) run(1, 0, 0, 0);
    run(0, 0, 0, 0);
    repeat (3) run(0, 0, 0, 0);
    repeat (C + S + 2) run(1, 0, 0, 0);
    samples(64, 1);

    run(0, 0, 0, 0);
    repeat (C + S + 3) run(1, 1, 0, 0);
    run(1, 0, 0, 0);
    samples(64, 0);

    samples(20, 3);
    async_rst();
    repeat (2) step(0, 0, 0, 0, 0);
    repeat (C + S + 2) run(1, 0, 0, 0);
    samples(64, 1);

    en_v = 1; fz_v = 0; bias = 50;
    for (int k = 0; k < 4000; k++) begin
      pfz = fz_v;
      if (k % 64 == 0) begin
        case ($urandom_range(2))
          0:       bias = 5;
          1:       bias = 50;
          default: bias = 95;
        endcase
      end
      if (!en_v) en_v = ($urandom_range(7) == 0);
      else en_v = ($urandom_range(599) != 0);
      if ($urandom_range(149) == 0) fz_v = !fz_v;
      ev = ($urandom_range(9) < 6);
      if (!en_v || fz_v != pfz) ev = 0;
      es = ($urandom_range(99) < bias);
      run(en_v, fz_v, ev, es);
    end

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sdm_nc_seq.md
Name: sdm_nc_seq

Overview:
Bring-up sequencer and gain-tracking controller for the SDM noise-cancellation path.
- On enable, clears the path's integrators, waits for the filter to settle, then tracks the cancellation gain word.
- Tracking is a windowed sign-sign loop driven by the residual-error sign.
- Runs in the clk_ref domain, next to the cancellation datapath.
- Drives the datapath's accumulator clear, its enable and the gain multiplicand.

Parameters:
W, 15, gain word width
GAIN_INIT, 15'h4000, gain value after reset
STEP_LOG2, 4, gain step = 2^STEP_LOG2
WIN_LOG2, 6, error samples per window = 2^WIN_LOG2
THRESH, 8, net sign count magnitude required to step the gain (1..2^WIN_LOG2)
CLR_CYC, 4, cycles acc_clr is held high (>=1)
SETTLE_CYC, 64, settle cycles after clear (>=1)
LOCK_WIN, 4, consecutive no-step windows needed to declare lock (>=1)

Ports:
clk  in  1  clk_ref-domain clock
rstn  in  1  asynchronous active-low reset (already synchronised to clk)
enable  in  1  level; 1 = run the cancellation path
freeze  in  1  level; 1 = hold the gain, ignore error samples
err_valid  in  1  strobe, one error sample this cycle
err_sign  in  1  sample sign; 1 = residual positive (gain too low)
acc_clr  out  1  synchronous clear to the datapath integrators
nc_en  out  1  datapath output enable
gain  out  W  cancellation gain word
locked  out  1  gain converged
busy  out  1  high in CLEAR and SETTLE

Behaviour:
- Reset values: state IDLE, acc_clr=0, nc_en=0, gain=GAIN_INIT, locked=0, busy=0. All internal counters reset to 0.
- All outputs are registered.
- States: IDLE, CLEAR, SETTLE, TRACK, HOLD.
- IDLE -> CLEAR on enable=1.
- CLEAR: acc_clr=1 for exactly CLR_CYC cycles, then SETTLE.
- SETTLE: SETTLE_CYC cycles, then TRACK. In TRACK, window counter and sum start at 0.
- TRACK -> HOLD when freeze=1. HOLD -> TRACK when freeze=0; a fresh window starts and the partial window is discarded.
- enable=0 in any state -> IDLE on the next edge. This has priority over every other transition.
- On leaving for IDLE: acc_clr, nc_en and locked clear; counters clear; gain is retained.
- nc_en=1 in TRACK and HOLD only.
- If freeze=1 on the SETTLE->TRACK edge, the state goes to HOLD instead.
- Window arithmetic:
  - Signed sum, WIN_LOG2+2 bits: +1 if err_sign=1, -1 otherwise.
  - Updated only on err_valid in TRACK. err_valid is ignored in all other states.
  - The 2^WIN_LOG2-th accepted sample closes the window. The decision includes that sample.
  - sum >= THRESH -> gain += 2^STEP_LOG2, saturating at 2^W-1.
  - sum <= -THRESH -> gain -= 2^STEP_LOG2, saturating at 0.
  - Otherwise no step.
  - gain updates on the same edge that registers the closing sample, so the new value is visible the following cycle. Sum and counter clear on that edge.
  - A step clamped to the limit with no change in value still counts as a step for lock purposes.
- Lock:
  - Lock counter increments on each no-step window and saturates at LOCK_WIN.
  - Any step zeroes the counter and clears locked on the same edge.
  - locked=1 while the counter equals LOCK_WIN.
  - locked is held through HOLD and cleared on leaving for IDLE.
- Async reset mid-operation: immediate return to reset values, including gain=GAIN_INIT.

Decomposition:
- Package sdm_nc_pkg holds:
  - the state enum (IDLE=0, CLEAR=1, SETTLE=2, TRACK=3, HOLD=4, 3 bits);
  - default-parameter constants;
  - the window-sum width function.
- One sub-module, sdm_nc_gain_step: saturating add/sub of the step on the W-bit gain. Combinational plus register, with its own async reset to GAIN_INIT.
- The FSM, phase counter, window and lock logic stay in sdm_nc_seq.

Test Plan:
1. Defaults. Reset, then enable=1:
   - acc_clr high exactly 4 cycles;
   - busy high for 68 cycles;
   - nc_en rises on cycle 69;
   - gain=16384 throughout.
2. TRACK, 64 samples all err_sign=1 -> gain=16400 one cycle after the 64th sample; locked stays 0.
3. TRACK, alternating signs (sum=0) for 4 windows -> gain unchanged at 16384; locked=1 after the 4th window closes. A following all-zero window -> gain=16368, locked=0.
4. Saturation:
   - GAIN_INIT=15'h7FF8, all-ones window -> gain=32767.
   - GAIN_INIT=8, all-zero window -> gain=0.
   - Lock counter resets in both cases.
5. freeze=1 after 30 samples, drive 100 err_valid while frozen, then release:
   - state HOLD, gain unchanged;
   - after release, a full fresh 64-sample window is required before any step.
6. Interrupts:
   - enable=0 during SETTLE -> IDLE next edge, nc_en=0, gain retained. Re-enable -> full CLEAR/SETTLE repeats.
   - rstn low during TRACK -> all outputs at reset values asynchronously.
